// File: rtl/board_pkg.sv
// Shared board definitions for the Arkanoid brick map.
//   - Board geometry: 4 rows x 4 columns, 16 tiles.
//   - Tile index convention: idx = row*4 + col (row in the upper two bits).
//   - Board controller FSM state encoding.
//   - Strength value loaded into present bricks when MULTI_HIT_EN is defined.
package board_pkg;

    localparam int unsigned BOARD_ROWS = 4;
    localparam int unsigned BOARD_COLS = 4;
    localparam int unsigned NUM_TILES  = BOARD_ROWS * BOARD_COLS;

    localparam logic [3:0] LAST_IDX      = 4'd15;
    localparam logic [1:0] STRENGTH_FULL = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StResolve,
        StWon
    } board_state_e;

    // row*4 + col with a 4-wide board is a plain concatenation
    function automatic logic [3:0] tile_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/frame_commit.sv
// Per-frame latch for a display overlay.
// Captures data_in on every rising edge of vsync_in and holds it otherwise, so the consumer
// never sees a change in the middle of a frame.
// Ports:
//   pclk      in   pixel clock
//   reset     in   asynchronous active-low reset
//   vsync_in  in   vertical sync; a rising edge commits data_in
//   data_in   in   live (shadow) data, WIDTH bits
//   data_out  out  committed data, WIDTH bits
module frame_commit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             vsync_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic             vsync_prev_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            vsync_prev_q <= 1'b0;
            data_q       <= '0;
        end else begin
            vsync_prev_q <= vsync_in;
            if (vsync_in && !vsync_prev_q) begin
                data_q <= data_in;
            end
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/board_ctrl.sv
// Arkanoid board controller: owns the 4x4 brick map, loads levels, resolves ball hits,
// keeps score and detects a cleared board. The bitmap seen by draw_board is committed only
// on a vsync rising edge.
// Optional feature macro: MULTI_HIT_EN (2-hit bricks with a per-brick strength counter and an
// extra strength_out port committed alongside tiles_out).
// Ports:
//   pclk           in   pixel clock, sole clock
//   reset          in   asynchronous active-low reset
//   vsync_in       in   vsync; rising edge commits the bitmap
//   level_start    in   one-cycle pulse, (re)loads INIT_MAP
//   hit_req        in   collision request, held until hit_ack
//   hit_row/col    in   brick coordinates of the request
//   hit_ack        out  one-cycle acknowledge
//   hit_destroyed  out  valid with hit_ack, 1 = a live brick was removed
//   tiles_out      out  committed 16-bit bitmap
//   bricks_left    out  live bricks in the shadow map
//   score          out  accumulated score (saturating)
//   board_clear    out  level won, held until next level_start
//   busy           out  high while loading
//   strength_out   out  (MULTI_HIT_EN only) committed 2-bit strength per tile
module board_ctrl
    import board_pkg::*;
#(
    parameter logic [15:0]  INIT_MAP = 16'hFFFF,
    parameter logic [7:0]   POINTS   = 8'd10,
    parameter int unsigned  SCORE_W  = 16
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               vsync_in,
    input  logic               level_start,
    input  logic               hit_req,
    input  logic [1:0]         hit_row,
    input  logic [1:0]         hit_col,
    output logic               hit_ack,
    output logic               hit_destroyed,
    output logic [15:0]        tiles_out,
    output logic [4:0]         bricks_left,
    output logic [SCORE_W-1:0] score,
    output logic               board_clear,
    output logic               busy
`ifdef MULTI_HIT_EN
    ,
    output logic [31:0]        strength_out
`endif
);

    board_state_e       state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [4:0]         bricks_left_q, bricks_left_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               board_clear_q;
    logic               hit_ack_q, hit_ack_d;
    logic               hit_destroyed_q, hit_destroyed_d;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic               req_new;
    logic               kill;

`ifdef MULTI_HIT_EN
    logic [31:0] strength_q, strength_d;
    localparam int unsigned COMMIT_W = 48;
    logic [COMMIT_W-1:0] commit_in, commit_out;
    assign commit_in    = {strength_q, shadow_q};
    assign tiles_out    = commit_out[15:0];
    assign strength_out = commit_out[47:16];
`else
    localparam int unsigned COMMIT_W = 16;
    logic [COMMIT_W-1:0] commit_in, commit_out;
    assign commit_in = shadow_q;
    assign tiles_out = commit_out;
`endif

    // One extra bit catches the carry so the score clamps instead of wrapping.
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    // While the ack is out the requester has not yet dropped hit_req; ignore it for that cycle.
    assign req_new = hit_req && !hit_ack_q;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        shadow_d        = shadow_q;
        bricks_left_d   = bricks_left_q;
        score_d         = score_q;
        hit_ack_d       = 1'b0;
        hit_destroyed_d = 1'b0;
        kill            = 1'b0;
`ifdef MULTI_HIT_EN
        strength_d      = strength_q;
`endif
        // level_start wins from any state; an in-flight hit is dropped without an ack.
        if (level_start) begin
            state_d       = StLoad;
            idx_d         = '0;
            bricks_left_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StWon: begin
                    if (req_new) begin
                        hit_ack_d = 1'b1;
                    end
                end
                StLoad: begin
                    shadow_d[idx_q] = INIT_MAP[idx_q];
                    bricks_left_d   = bricks_left_q + 5'(INIT_MAP[idx_q]);
`ifdef MULTI_HIT_EN
                    strength_d[{idx_q, 1'b0} +: 2] = INIT_MAP[idx_q] ? STRENGTH_FULL : 2'd0;
`endif
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = (bricks_left_d == '0) ? StWon : StPlay;
                    end
                end
                StPlay: begin
                    if (req_new) begin
                        idx_d   = tile_idx(hit_row, hit_col);
                        state_d = StResolve;
                    end
                end
                StResolve: begin
                    hit_ack_d = 1'b1;
`ifdef MULTI_HIT_EN
                    if (shadow_q[idx_q]) begin
                        kill = (strength_q[{idx_q, 1'b0} +: 2] == 2'd1);
                        strength_d[{idx_q, 1'b0} +: 2] = strength_q[{idx_q, 1'b0} +: 2] - 2'd1;
                    end
`else
                    kill = shadow_q[idx_q];
`endif
                    if (kill) begin
                        shadow_d[idx_q] = 1'b0;
                        bricks_left_d   = bricks_left_q - 5'd1;
                        score_d         = score_sat;
                        hit_destroyed_d = 1'b1;
                    end
                    state_d = (bricks_left_d == '0) ? StWon : StPlay;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            shadow_q        <= '0;
            bricks_left_q   <= '0;
            score_q         <= '0;
            board_clear_q   <= 1'b0;
            hit_ack_q       <= 1'b0;
            hit_destroyed_q <= 1'b0;
`ifdef MULTI_HIT_EN
            strength_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            shadow_q        <= shadow_d;
            bricks_left_q   <= bricks_left_d;
            score_q         <= score_d;
            board_clear_q   <= (state_d == StWon);
            hit_ack_q       <= hit_ack_d;
            hit_destroyed_q <= hit_destroyed_d;
`ifdef MULTI_HIT_EN
            strength_q      <= strength_d;
`endif
        end
    end

    frame_commit #(
        .WIDTH(COMMIT_W)
    ) u_frame_commit (
        .pclk     (pclk),
        .reset    (reset),
        .vsync_in (vsync_in),
        .data_in  (commit_in),
        .data_out (commit_out)
    );

    assign hit_ack       = hit_ack_q;
    assign hit_destroyed = hit_destroyed_q;
    assign bricks_left   = bricks_left_q;
    assign score         = score_q;
    assign board_clear   = board_clear_q;
    assign busy          = (state_q == StLoad);

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: directed scenarios plus randomized hits, vsync pulses
// and level restarts, compared against a tile-array reference model.
module tb_board_ctrl;

    localparam int SW        = 8;
    localparam int SCORE_MAX = (1 << SW) - 1;

    logic          pclk = 1'b0;
    logic          reset = 1'b0;
    logic          vsync_in = 1'b0;
    logic          level_start = 1'b0;
    logic          hit_req = 1'b0;
    logic [1:0]    hit_row = 2'd0;
    logic [1:0]    hit_col = 2'd0;
    logic          hit_ack;
    logic          hit_destroyed;
    logic [15:0]   tiles_out;
    logic [4:0]    bricks_left;
    logic [SW-1:0] score;
    logic          board_clear;
    logic          busy;
`ifdef MULTI_HIT_EN
    logic [31:0]   strength_out;
`endif

    always #5 pclk = ~pclk;

    board_ctrl #(
        .INIT_MAP (16'hFFFF),
        .POINTS   (8'd10),
        .SCORE_W  (SW)
    ) dut (
        .pclk          (pclk),
        .reset         (reset),
        .vsync_in      (vsync_in),
        .level_start   (level_start),
        .hit_req       (hit_req),
        .hit_row       (hit_row),
        .hit_col       (hit_col),
        .hit_ack       (hit_ack),
        .hit_destroyed (hit_destroyed),
        .tiles_out     (tiles_out),
        .bricks_left   (bricks_left),
        .score         (score),
        .board_clear   (board_clear),
        .busy          (busy)
`ifdef MULTI_HIT_EN
        ,
        .strength_out  (strength_out)
`endif
    );

    // Reference model: one entry per tile.
    logic [15:0] init_map = 16'hFFFF;
    bit          m_brick[16];
    int          m_str[16];
    int          m_score;
    bit          m_loaded;
    logic [15:0] m_committed;
    logic [31:0] m_str_commit;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    function automatic int m_left();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_brick[i]);
        return n;
    endfunction

    function automatic logic [15:0] m_tiles();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_brick[i];
        return v;
    endfunction

    function automatic logic [31:0] m_str_vec();
        logic [31:0] v;
        for (int i = 0; i < 16; i++) v[2*i +: 2] = 2'(m_str[i]);
        return v;
    endfunction

    task automatic model_load();
        for (int i = 0; i < 16; i++) begin
            m_brick[i] = init_map[i];
            m_str[i]   = init_map[i] ? 2 : 0;
        end
        m_loaded = 1'b1;
    endtask

    // Applies one hit to the model; returns expected destroyed flag and ack latency.
    task automatic model_hit(input int idx, output bit des, output int lat);
        bit play;
        play = m_loaded && (m_left() > 0);
        lat  = play ? 2 : 1;
        des  = 1'b0;
        if (play && m_brick[idx]) begin
`ifdef MULTI_HIT_EN
            des = (m_str[idx] == 1);
            m_str[idx]--;
`else
            des = 1'b1;
`endif
            if (des) begin
                m_brick[idx] = 1'b0;
                m_score = (m_score + 10 > SCORE_MAX) ? SCORE_MAX : m_score + 10;
            end
        end
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_left"},  32'(bricks_left), 32'(m_left()));
        check_val({tag, "_score"}, 32'(score),       32'(m_score));
        check_val({tag, "_clear"}, 32'(board_clear), 32'(m_loaded && m_left() == 0));
        check_val({tag, "_busy"},  32'(busy),        32'd0);
    endtask

    task automatic start_level();
        int cnt;
        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check_val("load_cycles", 32'(cnt), 32'd16);
        model_load();
        check_status("after_load");
    endtask

    task automatic vsync_pulse();
        check_val("tiles_hold", 32'(tiles_out), 32'(m_committed));
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        m_committed  = m_tiles();
        m_str_commit = m_str_vec();
        check_val("tiles_commit", 32'(tiles_out), 32'(m_committed));
`ifdef MULTI_HIT_EN
        check_val("strength_commit", strength_out, m_str_commit);
`endif
    endtask

    // Full request/ack handshake; vs_mid raises vsync during the cycle the hit resolves.
    task automatic do_hit(input int row, input int col, input bit vs_mid);
        bit          des;
        int          exp_lat, lat;
        logic [15:0] pre_tiles;
        logic [31:0] pre_str;
        pre_tiles = m_tiles();
        pre_str   = m_str_vec();
        model_hit(row * 4 + col, des, exp_lat);
        hit_row = 2'(row);
        hit_col = 2'(col);
        hit_req = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (vs_mid && lat == 1 && !hit_ack) vsync_in = 1'b1;
        end while (!hit_ack && lat < 20);
        hit_req = 1'b0;
        check_val("ack_latency", 32'(lat), 32'(exp_lat));
        check_val("destroyed", 32'(hit_destroyed), 32'(des));
        if (vs_mid && vsync_in) begin
            vsync_in     = 1'b0;
            m_committed  = pre_tiles;
            m_str_commit = pre_str;
            check_val("commit_prewrite", 32'(tiles_out), 32'(pre_tiles));
        end
        tick();
        check_val("ack_one_cycle", 32'(hit_ack), 32'd0);
        check_status("after_hit");
    endtask

    // level_start lands while the hit is resolving; the hit must be served after the reload.
    task automatic abandon_hit(input int row, input int col);
        int cnt, acks, lat, exp_lat;
        bit des;
        hit_row = 2'(row);
        hit_col = 2'(col);
        hit_req = 1'b1;
        tick();
        level_start = 1'b1;
        check_val("abandon_no_ack0", 32'(hit_ack), 32'd0);
        tick();
        level_start = 1'b0;
        cnt  = 0;
        acks = 0;
        while (busy && cnt < 40) begin
            if (hit_ack) acks++;
            cnt++;
            tick();
        end
        check_val("abandon_load_cycles", 32'(cnt), 32'd16);
        check_val("abandon_no_ack", 32'(acks), 32'd0);
        model_load();
        model_hit(row * 4 + col, des, exp_lat);
        lat = 0;
        while (!hit_ack && lat < 20) begin
            tick();
            lat++;
        end
        hit_req = 1'b0;
        check_val("abandon_latency", 32'(lat), 32'(exp_lat));
        check_val("abandon_destroyed", 32'(hit_destroyed), 32'(des));
        tick();
        check_status("after_abandon");
    endtask

    task automatic clear_board();
        int guard = 0;
        while (m_left() > 0 && guard < 40) begin
            for (int i = 0; i < 16; i++) begin
                if (m_brick[i]) begin
                    do_hit(i / 4, i % 4, 1'b0);
                    break;
                end
            end
            guard++;
        end
        check_val("board_won", 32'(board_clear), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        m_score      = 0;
        m_loaded     = 1'b0;
        m_committed  = '0;
        m_str_commit = '0;
        for (int i = 0; i < 16; i++) begin
            m_brick[i] = 1'b0;
            m_str[i]   = 0;
        end

        // Reset asserted in the middle of a load.
        tick();
        tick();
        reset = 1'b1;
        tick();
        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        tick();
        tick();
        tick();
        check_val("busy_mid_load", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("rst_async_busy",  32'(busy),      32'd0);
        check_val("rst_async_left",  32'(bricks_left), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("rst_tiles", 32'(tiles_out), 32'd0);
        check_val("rst_ack",   32'(hit_ack),   32'd0);
        check_val("rst_des",   32'(hit_destroyed), 32'd0);
        check_status("rst");
        do_hit(2, 1, 1'b0);

        // Level load and first frame commit.
        start_level();
        vsync_pulse();

`ifdef MULTI_HIT_EN
        do_hit(0, 0, 1'b0);
        vsync_pulse();
        do_hit(0, 0, 1'b0);
`endif

        // Hit idx 6; bitmap must not change before the next vsync.
        do_hit(1, 2, 1'b0);
        vsync_pulse();
        do_hit(1, 2, 1'b0);
        do_hit(1, 2, 1'b0);

        clear_board();
        do_hit(3, 3, 1'b0);
        start_level();
        abandon_hit(0, 0);

        // Commit and resolve in the same cycle.
        do_hit(2, 2, 1'b1);
        vsync_pulse();

        // Randomized traffic with occasional restarts.
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                vsync_pulse();
            end else if (r == 1) begin
                start_level();
            end else begin
                do_hit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r == 2);
            end
        end

        // Enough destroyed bricks to drive the 8-bit score into saturation.
        clear_board();
        start_level();
        clear_board();
        vsync_pulse();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
